// File: rtl/id_stage_unit.sv
// Instruction-decode stage: 16x32 register file with write-through reads, decode of the
// data-processing / LDR / STR / B subset, condition evaluation and the ID/EX register.
module id_stage_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        hazard,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  status,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] pc,
    output logic        wb_en_out,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        b,
    output logic        s,
    output logic        imm,
    output logic [3:0]  exe_cmd,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic [3:0]  dest,
    output logic        carry_in
);

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    logic [3:0] w_cond;
    logic [1:0] w_mode;
    logic       w_i;
    logic [3:0] w_opcode;
    logic       w_s;
    logic [3:0] w_rn;
    logic [3:0] w_rd;
    logic [3:0] w_rm;
    logic       w_is_str;

    assign w_cond   = instruction_in[31:28];
    assign w_mode   = instruction_in[27:26];
    assign w_i      = instruction_in[25];
    assign w_opcode = instruction_in[24:21];
    assign w_s      = instruction_in[20];
    assign w_rn     = instruction_in[19:16];
    assign w_rd     = instruction_in[15:12];
    assign w_rm     = instruction_in[3:0];
    assign w_is_str = (w_mode == 2'b01) && !w_s;

    assign src1    = w_rn;
    assign src2    = w_is_str ? w_rd : w_rm;
    assign two_src = ((w_mode == 2'b00) && !w_i) || w_is_str;

    logic [31:0] r_regs [16];

    // NOTE: the register file is reset on purpose -- R[i]=i after reset is visible to software.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 32'(i);
        end else if (wb_en) begin
            r_regs[wb_dest] <= wb_value;
        end
    end

    logic [31:0] w_val_rn;
    logic [31:0] w_val_rm;

    assign w_val_rn = (wb_en && wb_dest == src1) ? wb_value : r_regs[src1];
    assign w_val_rm = (wb_en && wb_dest == src2) ? wb_value : r_regs[src2];

    ctrl_t w_ctrl;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ctrl = '0;
        unique case (w_mode)
            2'b00: begin
                w_ctrl.wb_en = 1'b1;
                w_ctrl.s     = w_s;
                unique case (w_opcode)
                    4'b1101: w_ctrl.exe_cmd = 4'b0001;
                    4'b1111: w_ctrl.exe_cmd = 4'b1001;
                    4'b0100: w_ctrl.exe_cmd = 4'b0010;
                    4'b0101: w_ctrl.exe_cmd = 4'b0011;
                    4'b0010: w_ctrl.exe_cmd = 4'b0100;
                    4'b0110: w_ctrl.exe_cmd = 4'b0101;
                    4'b0000: w_ctrl.exe_cmd = 4'b0110;
                    4'b1100: w_ctrl.exe_cmd = 4'b0111;
                    4'b0001: w_ctrl.exe_cmd = 4'b1000;
                    4'b1010: begin w_ctrl.exe_cmd = 4'b0100; w_ctrl.wb_en = 1'b0; end
                    4'b1000: begin w_ctrl.exe_cmd = 4'b0110; w_ctrl.wb_en = 1'b0; end
                    default: w_ctrl = '0;
                endcase
            end
            2'b01: begin
                w_ctrl.exe_cmd  = 4'b0010;
                w_ctrl.mem_r_en = w_s;
                w_ctrl.wb_en    = w_s;
                w_ctrl.mem_w_en = !w_s;
            end
            2'b10:   w_ctrl.b = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ok;

    assign {w_n, w_z, w_c, w_v} = status;

    always_comb begin
        w_cond_ok = 1'b0;
        unique case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // A failed condition or a hazard bubble kills control only; operands still advance.
    ctrl_t w_ctrl_gated;
    assign w_ctrl_gated = (w_cond_ok && !hazard) ? w_ctrl : '0;

    ctrl_t       r_ctrl;
    logic [31:0] r_pc;
    logic        r_imm;
    logic [31:0] r_val_rn;
    logic [31:0] r_val_rm;
    logic [11:0] r_shift_operand;
    logic [23:0] r_signed_imm_24;
    logic [3:0]  r_dest;
    logic        r_carry_in;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ctrl          <= '0;
            r_pc            <= '0;
            r_imm           <= 1'b0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
            r_carry_in      <= 1'b0;
        end else if (!freeze) begin
            r_ctrl          <= w_ctrl_gated;
            r_pc            <= pc_in;
            r_imm           <= w_i;
            r_val_rn        <= w_val_rn;
            r_val_rm        <= w_val_rm;
            r_shift_operand <= instruction_in[11:0];
            r_signed_imm_24 <= instruction_in[23:0];
            r_dest          <= w_rd;
            r_carry_in      <= w_c;
        end
    end

    assign pc            = r_pc;
    assign wb_en_out     = r_ctrl.wb_en;
    assign mem_r_en      = r_ctrl.mem_r_en;
    assign mem_w_en      = r_ctrl.mem_w_en;
    assign b             = r_ctrl.b;
    assign s             = r_ctrl.s;
    assign exe_cmd       = r_ctrl.exe_cmd;
    assign imm           = r_imm;
    assign val_rn        = r_val_rn;
    assign val_rm        = r_val_rm;
    assign shift_operand = r_shift_operand;
    assign signed_imm_24 = r_signed_imm_24;
    assign dest          = r_dest;
    assign carry_in      = r_carry_in;

endmodule

// File: tb/tb_id_stage_unit.sv
// Self-checking bench for id_stage_unit: directed ARM instructions with literal expectations,
// then randomized traffic compared each cycle against a behavioural model of the stage.
module tb_id_stage_unit;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, hazard;
    logic [31:0] pc_in, instruction_in;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  status;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic [31:0] pc;
    logic        wb_en_out, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic        carry_in;

    always #5 clk = ~clk;

    id_stage_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .status(status),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pc(pc), .wb_en_out(wb_en_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s(s), .imm(imm), .exe_cmd(exe_cmd),
        .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .carry_in(carry_in)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        wb_en_out, mem_r_en, mem_w_en, b, s, imm;
        logic [3:0]  exe_cmd;
        logic [31:0] val_rn, val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic        carry_in;
    } out_t;

    out_t        exp_q;
    logic [31:0] m_regs [16];
    bit          model_valid = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // ARM pairs conditions: each odd code is the negation of the even code below it.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
        bit n, z, cf, v, base;
        {n, z, cf, v} = st;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic int dp_cmd(input logic [3:0] op);
        case (op)
            4'hD: return 1;  4'hF: return 9;
            4'h4: return 2;  4'h5: return 3;  4'h2: return 4;  4'h6: return 5;
            4'h0: return 6;  4'hC: return 7;  4'h1: return 8;
            4'hA: return 4;  4'h8: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
        return (wb_en && wb_dest == idx) ? wb_value : m_regs[idx];
    endfunction

    function automatic out_t predict(input logic [31:0] ins, input logic [31:0] pcv,
                                     input logic [3:0] st, input logic hz);
        out_t o;
        int   cmd;
        logic [1:0] mode;
        logic [3:0] rm_idx;
        o = '0;
        mode = ins[27:26];
        rm_idx = (mode == 2'd1 && !ins[20]) ? ins[15:12] : ins[3:0];
        o.pc = pcv;
        o.imm = ins[25];
        o.shift_operand = ins[11:0];
        o.signed_imm_24 = ins[23:0];
        o.dest = ins[15:12];
        o.carry_in = st[1];
        o.val_rn = mread(ins[19:16]);
        o.val_rm = mread(rm_idx);
        if (cond_ok(ins[31:28], st) && !hz) begin
            if (mode == 2'd0) begin
                cmd = dp_cmd(ins[24:21]);
                if (cmd >= 0) begin
                    o.exe_cmd = 4'(cmd);
                    o.wb_en_out = !(ins[24:21] == 4'hA || ins[24:21] == 4'h8);
                    o.s = ins[20];
                end
            end else if (mode == 2'd1) begin
                o.exe_cmd = 4'd2;
                o.mem_r_en = ins[20];
                o.wb_en_out = ins[20];
                o.mem_w_en = !ins[20];
            end else if (mode == 2'd2) begin
                o.b = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic compare_all();
        check("pc", pc, exp_q.pc);
        check("wb_en_out", 32'(wb_en_out), 32'(exp_q.wb_en_out));
        check("mem_r_en", 32'(mem_r_en), 32'(exp_q.mem_r_en));
        check("mem_w_en", 32'(mem_w_en), 32'(exp_q.mem_w_en));
        check("b", 32'(b), 32'(exp_q.b));
        check("s", 32'(s), 32'(exp_q.s));
        check("imm", 32'(imm), 32'(exp_q.imm));
        check("exe_cmd", 32'(exe_cmd), 32'(exp_q.exe_cmd));
        check("val_rn", val_rn, exp_q.val_rn);
        check("val_rm", val_rm, exp_q.val_rm);
        check("shift_operand", 32'(shift_operand), 32'(exp_q.shift_operand));
        check("signed_imm_24", 32'(signed_imm_24), 32'(exp_q.signed_imm_24));
        check("dest", 32'(dest), 32'(exp_q.dest));
        check("carry_in", 32'(carry_in), 32'(exp_q.carry_in));
    endtask

    // One clock: check combinational outputs, predict, clock, then check registered outputs.
    task automatic cycle();
        out_t       nxt;
        logic [1:0] mode;
        #1;
        mode = instruction_in[27:26];
        if (model_valid) begin
            check("src1", 32'(src1), 32'(instruction_in[19:16]));
            check("src2", 32'(src2), 32'((mode == 2'd1 && !instruction_in[20]) ?
                                         instruction_in[15:12] : instruction_in[3:0]));
            check("two_src", 32'(two_src), 32'((mode == 2'd0 && !instruction_in[25]) ||
                                               (mode == 2'd1 && !instruction_in[20])));
        end
        if (rst || flush)  nxt = '0;
        else if (freeze)   nxt = exp_q;
        else               nxt = predict(instruction_in, pc_in, status, hazard);
        @(posedge clk);
        exp_q = nxt;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'(i);
            model_valid = 1;
        end else if (wb_en) begin
            m_regs[wb_dest] = wb_value;
        end
        @(negedge clk);
        if (model_valid) compare_all();
    endtask

    task automatic idle();
        rst = 0; freeze = 0; flush = 0; hazard = 0;
        wb_en = 0; wb_dest = 0; wb_value = 0; status = 0; pc_in = 0;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pcv);
        instruction_in = ins;
        pc_in = pcv;
        cycle();
    endtask

    initial begin
        idle();
        instruction_in = 32'h0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        run(32'h0, 32'h0);
        check("reset exe_cmd", 32'(exe_cmd), 32'h0);
        check("reset wb_en_out", 32'(wb_en_out), 32'h0);
        check("reset val_rn", val_rn, 32'h0);
        check("reset pc", pc, 32'h0);

        run(32'hE080_2001, 32'h4);
        check("add exe_cmd", 32'(exe_cmd), 32'h2);
        check("add wb_en_out", 32'(wb_en_out), 32'h1);
        check("add dest", 32'(dest), 32'h2);
        check("add val_rn", val_rn, 32'h0);
        check("add val_rm", val_rm, 32'h1);
        check("add two_src", 32'(two_src), 32'h1);

        run(32'hE3A0_0014, 32'h8);
        check("mov exe_cmd", 32'(exe_cmd), 32'h1);
        check("mov imm", 32'(imm), 32'h1);
        check("mov shift_operand", 32'(shift_operand), 32'h014);

        run(32'h03A0_0014, 32'hC);
        check("moveq exe_cmd", 32'(exe_cmd), 32'h0);
        check("moveq wb_en_out", 32'(wb_en_out), 32'h0);
        check("moveq dest", 32'(dest), 32'h0);

        wb_en = 1; wb_dest = 4'd1; wb_value = 32'h55;
        run(32'hE080_2001, 32'h10);
        check("bypass val_rm", val_rm, 32'h55);
        wb_en = 0;
        run(32'hE080_2001, 32'h14);
        check("stored val_rm", val_rm, 32'h55);

        run(32'hE580_1004, 32'h18);
        check("str src2", 32'(src2), 32'h1);
        check("str two_src", 32'(two_src), 32'h1);
        check("str mem_w_en", 32'(mem_w_en), 32'h1);
        check("str exe_cmd", 32'(exe_cmd), 32'h2);
        check("str s", 32'(s), 32'h0);

        run(32'hE590_1004, 32'h1C);
        check("ldr mem_r_en", 32'(mem_r_en), 32'h1);
        check("ldr wb_en_out", 32'(wb_en_out), 32'h1);

        run(32'hEAFF_FFFE, 32'h20);
        check("b b", 32'(b), 32'h1);
        check("b signed_imm_24", 32'(signed_imm_24), 32'hFF_FFFE);

        flush = 1;
        run(32'hE080_2001, 32'h24);
        flush = 0;
        check("flush b", 32'(b), 32'h0);
        check("flush pc", pc, 32'h0);
        check("flush val_rm", val_rm, 32'h0);

        run(32'hE080_2001, 32'h100);
        freeze = 1;
        run(32'hE3A0_0014, 32'h200);
        freeze = 0;
        check("freeze pc", pc, 32'h100);
        check("freeze exe_cmd", 32'(exe_cmd), 32'h2);

        hazard = 1;
        run(32'hE084_3005, 32'h204);
        check("hazard exe_cmd", 32'(exe_cmd), 32'h0);
        check("hazard wb_en_out", 32'(wb_en_out), 32'h0);
        check("hazard val_rn", val_rn, 32'h4);
        check("hazard val_rm", val_rm, 32'h5);
        freeze = 1;
        run(32'hE3A0_0014, 32'h208);
        check("hazard+freeze val_rn", val_rn, 32'h4);
        check("hazard+freeze dest", 32'(dest), 32'h3);
        idle();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
            rst    = ($urandom_range(199, 0) == 0);
            flush  = ($urandom_range(9, 0) == 0);
            freeze = ($urandom_range(7, 0) == 0);
            hazard = ($urandom_range(7, 0) == 0);
            wb_en  = $urandom_range(1, 0) == 1;
            wb_dest = ($urandom_range(2, 0) == 0) ? ins[19:16] : 4'($urandom);
            wb_value = $urandom;
            status = 4'($urandom);
            run(ins, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
